// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencing for the ID/EX boundary: load-use stalls, taken-branch flushes,
// memory-busy freezes, a saturating stall counter and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
    parameter int         REG_INDEX_BIT_WIDTH = 4,
    parameter logic [3:0] OP_LW               = 4'b0001,
    parameter logic [3:0] OP_SW               = 4'b0011,
    parameter logic [3:0] OP_BRANCH           = 4'b0010,
    parameter int         MEM_TIMEOUT         = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           id_valid,
    input  logic [3:0]                     id_opcode,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_rs,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_rt,
    input  logic                           ex_valid,
    input  logic [3:0]                     ex_opcode,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] ex_rd,
    input  logic                           branch_taken,
    input  logic                           mem_req,
    input  logic                           mem_ready,
    input  logic                           stat_clr,
    output logic                           pc_write,
    output logic                           ifid_write,
    output logic                           idex_bubble,
    output logic                           ifid_flush,
    output logic                           idex_flush,
    output logic                           pipe_freeze,
    output logic [15:0]                    stall_count,
    output logic                           mem_timeout
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [WCW-1:0] r_wait_cnt;
    logic [15:0]    r_stall_count;
    logic           r_mem_timeout;

    logic w_freeze;
    logic w_branch;
    logic w_rt_is_src;
    logic w_load_use;

    assign w_freeze = mem_req && !mem_ready;
    assign w_branch = ex_valid && (ex_opcode == OP_BRANCH) && branch_taken;

    // Stores read rt as write data; only a load uses rt as its destination.
    assign w_rt_is_src = (id_opcode == OP_SW) || (id_opcode != OP_LW);
    assign w_load_use  = ex_valid && (ex_opcode == OP_LW) && id_valid &&
                         ((id_rs == ex_rd) || (w_rt_is_src && (id_rt == ex_rd)));

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        if (!rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_freeze) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else if (w_branch) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN:      if (w_freeze)  w_next_state = MEM_WAIT;
            MEM_WAIT: if (!w_freeze) w_next_state = RUN;
            default:  w_next_state = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_freeze) begin
                if (r_wait_cnt != WCW'(MEM_TIMEOUT))
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                if (r_wait_cnt >= WCW'(MEM_TIMEOUT - 1))
                    r_mem_timeout <= 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_stall_count <= 16'h0000;
        else if (stat_clr)
            r_stall_count <= 16'h0000;
        else if (!pc_write && (r_stall_count != 16'hFFFF))
            r_stall_count <= r_stall_count + 16'h0001;
    end

    assign stall_count = r_stall_count;
    assign mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT shortened to 4).
module tb_pipeline_hazard_ctrl;

    localparam int         TO        = 4;
    localparam logic [3:0] LW        = 4'b0001;
    localparam logic [3:0] SW        = 4'b0011;
    localparam logic [3:0] BR        = 4'b0010;
    localparam logic [3:0] ADD       = 4'b1100;

    typedef struct packed {
        logic pcWrite;
        logic ifidWrite;
        logic idexBubble;
        logic ifidFlush;
        logic idexFlush;
        logic pipeFreeze;
    } ctrl_t;

    logic        clk;
    logic        rst;
    logic        idValid;
    logic [3:0]  idOpcode;
    logic [3:0]  idRs;
    logic [3:0]  idRt;
    logic        exValid;
    logic [3:0]  exOpcode;
    logic [3:0]  exRd;
    logic        branchTaken;
    logic        memReq;
    logic        memReady;
    logic        statClr;
    logic        pcWrite;
    logic        ifidWrite;
    logic        idexBubble;
    logic        ifidFlush;
    logic        idexFlush;
    logic        pipeFreeze;
    logic [15:0] stallCount;
    logic        memTimeout;

    int    checks   = 0;
    int    failures = 0;
    ctrl_t expQ[$];

    int          mWait;
    logic [15:0] mStall;
    logic        mTimeout;

    pipeline_hazard_ctrl #(
        .REG_INDEX_BIT_WIDTH(4),
        .OP_LW(LW),
        .OP_SW(SW),
        .OP_BRANCH(BR),
        .MEM_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .id_valid(idValid),
        .id_opcode(idOpcode),
        .id_rs(idRs),
        .id_rt(idRt),
        .ex_valid(exValid),
        .ex_opcode(exOpcode),
        .ex_rd(exRd),
        .branch_taken(branchTaken),
        .mem_req(memReq),
        .mem_ready(memReady),
        .stat_clr(statClr),
        .pc_write(pcWrite),
        .ifid_write(ifidWrite),
        .idex_bubble(idexBubble),
        .ifid_flush(ifidFlush),
        .idex_flush(idexFlush),
        .pipe_freeze(pipeFreeze),
        .stall_count(stallCount),
        .mem_timeout(memTimeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic ctrl_t modelCtrl();
        ctrl_t c;
        c = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        if (!rst)
            c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        else if (memReq && !memReady)
            c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        else if (exValid && exOpcode == BR && branchTaken)
            c = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        else if (exValid && exOpcode == LW && idValid &&
                 (idRs == exRd || (idOpcode != LW && idRt == exRd)))
            c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [3:0] iop, input logic [3:0] rs,
                         input logic [3:0] rt, input logic ev, input logic [3:0] eop,
                         input logic [3:0] rd, input logic bt, input logic mq, input logic mr);
        idValid = iv; idOpcode = iop; idRs = rs; idRt = rt;
        exValid = ev; exOpcode = eop; exRd = rd; branchTaken = bt;
        memReq = mq; memReady = mr;
    endtask

    // One clock: push expected controls, compare them mid-cycle, then step the counter model.
    task automatic applyStimulus(input string tag, input bit chk);
        ctrl_t exp;
        ctrl_t obs;
        expQ.push_back(modelCtrl());
        @(negedge clk);
        exp = expQ.pop_front();
        obs = '{pcWrite, ifidWrite, idexBubble, ifidFlush, idexFlush, pipeFreeze};
        if (chk) checkOutput({tag, ".ctrl"}, 32'(obs), 32'(exp));
        @(posedge clk);
        if (!rst) begin
            mWait = 0; mStall = 16'h0000; mTimeout = 1'b0;
        end else begin
            if (statClr) mStall = 16'h0000;
            else if (!exp.pcWrite && mStall != 16'hFFFF) mStall = mStall + 16'h0001;
            if (exp.pipeFreeze) begin
                if (mWait >= TO - 1) mTimeout = 1'b1;
                if (mWait < TO) mWait++;
            end else begin
                mWait = 0;
            end
        end
        #1;
        if (chk) begin
            checkOutput({tag, ".stall_count"}, 32'(stallCount), 32'(mStall));
            checkOutput({tag, ".mem_timeout"}, 32'(memTimeout), 32'(mTimeout));
        end
    endtask

    initial begin
        mWait = 0; mStall = 16'h0000; mTimeout = 1'b0;
        rst = 1'b0; statClr = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus("rst_init0", 1'b1);
        applyStimulus("rst_init1", 1'b1);
        rst = 1'b1;
        applyStimulus("pre_freeze0", 1'b1);
        applyStimulus("pre_freeze1", 1'b1);
        rst = 1'b0;
        applyStimulus("rst_mid_freeze0", 1'b1);
        applyStimulus("rst_mid_freeze1", 1'b1);
        rst = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus("idle", 1'b1);

        drive(1'b1, ADD, 4'd3, 4'd7, 1'b1, LW, 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus("lu_add_rs", 1'b1);
        drive(1'b1, ADD, 4'd3, 4'd7, 1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus("lu_after_bubble", 1'b1);
        drive(1'b1, SW, 4'd1, 4'd3, 1'b1, LW, 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus("lu_sw_rt", 1'b1);
        drive(1'b1, LW, 4'd5, 4'd3, 1'b1, LW, 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus("lu_lw_rt_ignored", 1'b1);
        drive(1'b1, ADD, 4'd0, 4'd9, 1'b1, LW, 4'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus("lu_index0", 1'b1);
        drive(1'b0, ADD, 4'd3, 4'd3, 1'b1, LW, 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus("lu_id_invalid", 1'b1);

        drive(1'b1, ADD, 4'd3, 4'd3, 1'b1, BR, 4'd3, 1'b1, 1'b0, 1'b0);
        applyStimulus("br_taken", 1'b1);
        drive(1'b1, ADD, 4'd3, 4'd3, 1'b1, BR, 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus("br_not_taken", 1'b1);

        drive(1'b1, ADD, 4'd1, 4'd2, 1'b1, ADD, 4'd4, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus("mem_wait", 1'b1);
        memReady = 1'b1;
        applyStimulus("mem_ready", 1'b1);
        drive(1'b1, ADD, 4'd1, 4'd2, 1'b1, ADD, 4'd4, 1'b0, 1'b0, 1'b0);
        applyStimulus("mem_done", 1'b1);

        drive(1'b1, ADD, 4'd1, 4'd2, 1'b1, BR, 4'd4, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < TO; i++) applyStimulus("to_freeze", 1'b1);
        applyStimulus("to_freeze_more", 1'b1);
        memReady = 1'b1;
        applyStimulus("to_flush_after", 1'b1);
        drive(1'b1, ADD, 4'd1, 4'd2, 1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus("to_sticky", 1'b1);

        drive(1'b1, ADD, 4'd6, 4'd2, 1'b1, LW, 4'd6, 1'b0, 1'b0, 1'b0);
        statClr = 1'b1;
        applyStimulus("clr_in_stall", 1'b1);
        statClr = 1'b0;
        for (int i = 0; i < 65540; i++) applyStimulus("bulk", 1'b0);
        applyStimulus("saturate", 1'b1);
        statClr = 1'b1;
        applyStimulus("clr_after_sat", 1'b1);
        statClr = 1'b0;
        applyStimulus("count_restart", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
